// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder backed by a
// 2^DEPTH_LOG2 x 32-bit word store, with WAIT_CYCLES programmable wait states.
// Optional feature macro: MISALIGN_CHECK_EN (reject accesses with addr[1:0] != 0).
// The FSM enters RESP on the commit edge; the registered response handshake
// signals follow one cycle later, giving resp_valid at accept edge + WAIT_CYCLES + 1.
module data_mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = DEPTH_LOG2;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              accept_c;
  logic              commit_c;
  logic              resp_valid_next_c;

  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              commit_we_c;
  logic [IDX_W-1:0]  commit_idx_c;
  logic [DATA_W-1:0] commit_wdata_c;
  logic              mis_c;

  logic [DATA_W-1:0] mem [DEPTH];

  // State and wait-counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic, acceptance and commit strobes
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept_c   = 1'b0;
    commit_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept_c = 1'b1;
          cnt_next = '0;
          if (WAIT_CYCLES == 0) begin
            state_next = ST_RESP;
            commit_c   = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_LAST) begin
          state_next = ST_RESP;
          commit_c   = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_valid && resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Response is presented only while RESP persists past this edge
  assign resp_valid_next_c = (state == ST_RESP) && (state_next == ST_RESP);

  // With zero wait states the commit uses the live request, otherwise the captured one
  assign commit_we_c    = (state == ST_IDLE) ? req_we : we_q;
  assign commit_idx_c   = (state == ST_IDLE) ? req_addr[DEPTH_LOG2+1:2] : idx_q;
  assign commit_wdata_c = (state == ST_IDLE) ? req_wdata : wdata_q;

`ifdef MISALIGN_CHECK_EN
  logic mis_q;
  logic err_q;
  logic unused_addr;
  assign unused_addr = ^req_addr[31:DEPTH_LOG2+2];
  assign mis_c       = (state == ST_IDLE) ? (req_addr[1:0] != 2'b00) : mis_q;

  // Misalignment flag captured at accept, error latched at commit, presented with response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      if (accept_c) begin
        mis_q <= (req_addr[1:0] != 2'b00);
      end
      if (commit_c) begin
        err_q <= mis_c;
      end
      resp_err <= resp_valid_next_c ? err_q : 1'b0;
    end
  end
`else
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
  assign mis_c       = 1'b0;
  assign resp_err    = 1'b0;
`endif

  // Request capture at accept, load data capture at commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept_c) begin
        we_q    <= req_we;
        idx_q   <= req_addr[DEPTH_LOG2+1:2];
        wdata_q <= req_wdata;
      end
      if (commit_c) begin
        rdata_q <= (commit_we_c || mis_c) ? '0 : mem[commit_idx_c];
      end
    end
  end

  // Word storage, cleared by reset, written only on a committed aligned store
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (commit_c && commit_we_c && !mis_c) begin
      mem[commit_idx_c] <= commit_wdata_c;
    end
  end

  // Registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      req_ready  <= (state_next == ST_IDLE);
      busy       <= (state_next != ST_IDLE);
      resp_valid <= resp_valid_next_c;
      resp_rdata <= resp_valid_next_c ? rdata_q : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected responses are queued at
// request acceptance and compared when the response handshake happens.
module tb_data_mem_responder;

  localparam int unsigned DEPTH_LOG2  = 6;
  localparam int unsigned WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          lat_pending = 1'b0;
  logic [32:0] sb [$];
  logic [31:0] model [64];

  data_mem_responder #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request from a negedge; returns at the negedge after acceptance
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int          n;
    logic        mis;
    logic [31:0] exp_d;
    logic [5:0]  idx;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check_eq("req_ready_timeout", 32'(req_ready), 32'd1);
    mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
    mis = (addr[1:0] != 2'b00);
`endif
    idx = addr[7:2];
    if (mis) begin
      exp_d = 32'd0;
    end else if (we) begin
      exp_d      = 32'd0;
      model[idx] = wdata;
    end else begin
      exp_d = model[idx];
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid   = 1'b0;
    req_we      = 1'($urandom);
    req_addr    = $urandom;
    req_wdata   = $urandom;
    acc_cyc     = cyc;
    lat_pending = 1'b1;
    sb.push_back({mis, exp_d});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Response monitor: latency, scoreboard compare, idle-zero outputs
  always @(negedge clk) begin : mon
    logic [32:0] e;
    #1;
    if (rst) begin
      if (resp_valid) begin
        if (lat_pending) begin
          check_eq("latency", 32'(cyc - acc_cyc), 32'(WAIT_CYCLES + 1));
          lat_pending = 1'b0;
        end
        if (resp_ready) begin
          if (sb.size() == 0) begin
            check_eq("stray_resp", 32'(resp_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            check_eq("rdata", resp_rdata, e[31:0]);
            check_eq("err", 32'(resp_err), 32'(e[32]));
          end
        end
      end else begin
        check_eq("idle_rdata", resp_rdata, 32'd0);
        check_eq("idle_err", 32'(resp_err), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] a;
    logic [31:0] d;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < 64; i++) model[i] = 32'd0;

    // Reset then idle
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    do_req(1'b0, 32'h0, 32'h0);
    check_eq("wait_busy", 32'(busy), 32'd1);
    check_eq("wait_req_ready", 32'(req_ready), 32'd0);
    drain();

    // Store then load
    do_req(1'b1, 32'h10, 32'hDEADBEEF);
    drain();
    do_req(1'b0, 32'h10, 32'h0);
    drain();

    // Address wrap
    do_req(1'b1, 32'h104, 32'h12345678);
    drain();
    do_req(1'b0, 32'h004, 32'h0);
    drain();

    // Backpressure with an ignored second request
    resp_ready = 1'b0;
    do_req(1'b0, 32'h10, 32'h0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_valid_rise", 32'(resp_valid), 32'd1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h55555555;
    repeat (5) begin
      check_eq("bp_valid", 32'(resp_valid), 32'd1);
      check_eq("bp_rdata", resp_rdata, 32'hDEADBEEF);
      check_eq("bp_req_ready", 32'(req_ready), 32'd0);
      check_eq("bp_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("bp_done_valid", 32'(resp_valid), 32'd0);
    check_eq("bp_done_ready", 32'(req_ready), 32'd1);
    check_eq("bp_done_busy", 32'(busy), 32'd0);
    check_eq("bp_sb_empty", 32'(sb.size()), 32'd0);
    do_req(1'b0, 32'h10, 32'h0);
    drain();

    // Reset during WAIT drops the store
    do_req(1'b1, 32'h20, 32'hAAAA5555);
    rst = 1'b0;
    sb.delete();
    lat_pending = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("midrst_valid", 32'(resp_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    do_req(1'b0, 32'h20, 32'h0);
    drain();
    do_req(1'b0, 32'h10, 32'h0);
    drain();

    // Low address bits: rejected with the check, ignored without it
    do_req(1'b1, 32'h22, 32'hFFFFFFFF);
    drain();
    do_req(1'b0, 32'h20, 32'h0);
    drain();
    do_req(1'b0, 32'h23, 32'h0);
    drain();

    // Random store/load pairs, loads through an aliased address
    for (int i = 0; i < 12; i++) begin
      a = $urandom & 32'h0000_0FFC;
      d = $urandom;
      do_req(1'b1, a, d);
      do_req(1'b0, a ^ 32'h0000_0300, 32'h0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
